// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
// Holds the FSM state encoding, the default frame header and the err_code values.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DHI  = 3'd3,
    ST_DLO  = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'h55;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Byte handshake between a UART receiver (master) and the frame controller (slave).
// rx_rdy is a level held by the receiver until rx_rdy_clr is pulsed.
interface uart_frame_ctrl_if;

  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_rdy_clr;

  modport master (
    output rx_rdy,
    output rx_data,
    input  rx_rdy_clr
  );

  modport slave (
    input  rx_rdy,
    input  rx_data,
    output rx_rdy_clr
  );

endinterface

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter: counts while enabled, raises expire at TIMEOUT_CYC-1.
// clr has priority over counting; the counter parks at its last value until cleared.
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame assembler: HEADER, cmd, addr, data_hi, data_lo, csum from a byte-level UART receiver.
// Reports good frames with frm_valid, checksum/timeout failures with frm_err/err_code.
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  HEADER      = DEFAULT_HEADER
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  uart_frame_ctrl_if.slave    rx,
  output logic                frm_valid,
  output logic [7:0]          frm_cmd,
  output logic [7:0]          frm_addr,
  output logic [15:0]         frm_wdata,
  output logic                frm_err,
  output logic [1:0]          err_code,
  output logic                busy,
  output logic [7:0]          frame_cnt,
  output logic [7:0]          err_cnt
);

  state_t     state, state_nxt;
  logic       accept;
  logic       good, bad, tmo;
  logic       expire;
  logic [7:0] sum;
  logic [7:0] cmd_q, addr_q, dhi_q, dlo_q;

  // The clear pulse blocks a second take of the byte still shown during that cycle.
  assign accept = rx.rx_rdy && !rx.rx_rdy_clr;
  assign busy   = (state != ST_IDLE);

  uart_frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .clr     (accept || (state == ST_IDLE)),
    .en      (state != ST_IDLE),
    .expire  (expire)
  );

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    good      = 1'b0;
    bad       = 1'b0;
    tmo       = 1'b0;
    if (accept) begin
      unique case (state)
        ST_IDLE: if (rx.rx_data == HEADER) state_nxt = ST_CMD;
        ST_CMD:  state_nxt = ST_ADDR;
        ST_ADDR: state_nxt = ST_DHI;
        ST_DHI:  state_nxt = ST_DLO;
        ST_DLO:  state_nxt = ST_CSUM;
        ST_CSUM: begin
          state_nxt = ST_IDLE;
          if (rx.rx_data == sum) good = 1'b1;
          else                   bad  = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (expire) begin
      // A byte arriving in the expiry cycle takes the branch above instead.
      state_nxt = ST_IDLE;
      tmo       = 1'b1;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx.rx_rdy_clr <= 1'b0;
      sum           <= '0;
      cmd_q         <= '0;
      addr_q        <= '0;
      dhi_q         <= '0;
      dlo_q         <= '0;
      frm_valid     <= 1'b0;
      frm_err       <= 1'b0;
      err_code      <= ERR_NONE;
      frm_cmd       <= '0;
      frm_addr      <= '0;
      frm_wdata     <= '0;
      frame_cnt     <= '0;
      err_cnt       <= '0;
    end else begin
      rx.rx_rdy_clr <= accept;
      frm_valid     <= good;
      frm_err       <= bad || tmo;

      if (accept) begin
        unique case (state)
          ST_IDLE: sum <= '0;
          ST_CMD:  begin cmd_q  <= rx.rx_data; sum <= sum + rx.rx_data; end
          ST_ADDR: begin addr_q <= rx.rx_data; sum <= sum + rx.rx_data; end
          ST_DHI:  begin dhi_q  <= rx.rx_data; sum <= sum + rx.rx_data; end
          ST_DLO:  begin dlo_q  <= rx.rx_data; sum <= sum + rx.rx_data; end
          default: ;
        endcase
      end

      if (good) begin
        frm_cmd   <= cmd_q;
        frm_addr  <= addr_q;
        frm_wdata <= {dhi_q, dlo_q};
        frame_cnt <= frame_cnt + 8'd1;
      end

      if (bad || tmo) begin
        err_code <= bad ? ERR_CSUM : ERR_TIMEOUT;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames plus randomized traffic
// compared against a queue-based frame model; the bench plays the UART receiver.
module tb_uart_frame_ctrl;
  import uart_frame_pkg::*;

  localparam int unsigned T   = 64;
  localparam logic [7:0]  HDR = 8'h55;

  logic        clk_50m = 1'b0;
  logic        rst_n   = 1'b0;
  logic        frm_valid, frm_err, busy;
  logic [7:0]  frm_cmd, frm_addr, frame_cnt, err_cnt;
  logic [15:0] frm_wdata;
  logic [1:0]  err_code;

  uart_frame_ctrl_if bus ();

  uart_frame_ctrl #(
    .TIMEOUT_CYC (T),
    .HEADER      (HDR)
  ) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .rx        (bus),
    .frm_valid (frm_valid),
    .frm_cmd   (frm_cmd),
    .frm_addr  (frm_addr),
    .frm_wdata (frm_wdata),
    .frm_err   (frm_err),
    .err_code  (err_code),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  int errors = 0;
  int checks = 0;
  int sent   = 0;
  int clr_pulses = 0;
  int both_cnt   = 0;

  // Reference model: bytes of the frame in progress plus the visible result registers.
  logic [7:0]  frame_q[$];
  logic [7:0]  m_cmd, m_addr, m_fcnt, m_ecnt;
  logic [15:0] m_wdata;
  logic [1:0]  m_code;
  logic        exp_valid, exp_err;

  always @(negedge clk_50m) begin
    if (bus.rx_rdy_clr) clr_pulses++;
    if (frm_valid && frm_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_cmd = 8'h00; m_addr = 8'h00; m_wdata = 16'h0000;
    m_fcnt = 8'h00; m_ecnt = 8'h00; m_code = ERR_NONE;
  endtask

  task automatic model_error(input logic [1:0] code);
    m_code = code;
    if (m_ecnt < 8'd255) m_ecnt = m_ecnt + 8'd1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] s;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (frame_q.size() == 0) begin
      if (b == HDR) frame_q.push_back(b);
    end else begin
      frame_q.push_back(b);
      if (frame_q.size() == 6) begin
        s = frame_q[1] + frame_q[2] + frame_q[3] + frame_q[4];
        if (s == frame_q[5]) begin
          m_cmd     = frame_q[1];
          m_addr    = frame_q[2];
          m_wdata   = {frame_q[3], frame_q[4]};
          m_fcnt    = m_fcnt + 8'd1;
          exp_valid = 1'b1;
        end else begin
          model_error(ERR_CSUM);
          exp_err = 1'b1;
        end
        frame_q.delete();
      end
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_cmd"},   frm_cmd,   m_cmd);
    check({tag, "_addr"},  frm_addr,  m_addr);
    check({tag, "_wdata"}, frm_wdata, m_wdata);
    check({tag, "_fcnt"},  frame_cnt, m_fcnt);
    check({tag, "_ecnt"},  err_cnt,   m_ecnt);
    check({tag, "_code"},  err_code,  m_code);
  endtask

  // Called just after a falling edge; models a receiver that clears rx_rdy
  // on the edge where it sees rx_rdy_clr, so rx_rdy overlaps the clear cycle.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic seen;
    seen = 1'b0;
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk_50m);
      if (bus.rx_rdy_clr) seen = 1'b1;
    end
    check("byte_taken", seen, 1'b1);
    sent++;
    model_byte(b);
    check("valid", frm_valid, exp_valid);
    check("err",   frm_err,   exp_err);
    check("busy",  busy,      frame_q.size() != 0);
    check_regs("byte");
    @(negedge clk_50m);
    bus.rx_rdy = 1'b0;
    check("clr_width",   bus.rx_rdy_clr, 1'b0);
    check("valid_width", frm_valid,      1'b0);
    check("err_width",   frm_err,        1'b0);
    repeat (gap) @(negedge clk_50m);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [15:0] w, input logic corrupt);
    logic [7:0] cs;
    cs = c + a + w[15:8] + w[7:0] + {7'd0, corrupt};
    send_byte(HDR,     $urandom_range(0, 2));
    send_byte(c,       $urandom_range(0, 2));
    send_byte(a,       $urandom_range(0, 2));
    send_byte(w[15:8], $urandom_range(0, 2));
    send_byte(w[7:0],  $urandom_range(0, 2));
    send_byte(cs,      $urandom_range(0, 2));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
  endtask

  initial begin
    logic        found;
    int          elapsed;
    logic [7:0]  nb;

    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk_50m);
    check("rst_valid", frm_valid, 1'b0);
    check("rst_err",   frm_err,   1'b0);
    check("rst_busy",  busy,      1'b0);
    check("rst_clr",   bus.rx_rdy_clr, 1'b0);
    check_regs("rst");
    rst_n = 1'b1;
    @(negedge clk_50m);

    // Good frame, then the same frame with a bad checksum.
    send_frame(8'h01, 8'h10, 16'h1234, 1'b0);
    check("good_cmd",   frm_cmd,   8'h01);
    check("good_wdata", frm_wdata, 16'h1234);
    check("good_fcnt",  frame_cnt, 8'd1);
    check("good_ecnt",  err_cnt,   8'd0);
    send_frame(8'h01, 8'h10, 16'h1234, 1'b1);
    check("bad_code",  err_code,  ERR_CSUM);
    check("bad_ecnt",  err_cnt,   8'd1);
    check("bad_addr",  frm_addr,  8'h10);
    check("bad_fcnt",  frame_cnt, 8'd1);

    // Noise bytes in IDLE are dropped silently.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_frame(8'h02, 8'h00, 16'h0001, 1'b0);
    check("noise_cmd",   frm_cmd,   8'h02);
    check("noise_wdata", frm_wdata, 16'h0001);
    check("noise_ecnt",  err_cnt,   8'd1);

    // HEADER values inside the frame are ordinary data.
    send_frame(HDR, HDR, {HDR, HDR}, 1'b0);
    check("hdr_data_wdata", frm_wdata, 16'h5555);

    // Timeout after a partial frame.
    send_byte(HDR, 0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    found   = 1'b0;
    elapsed = 0;
    for (int i = 0; i < 3 * int'(T) && !found; i++) begin
      @(negedge clk_50m);
      if (frm_err) begin
        found   = 1'b1;
        elapsed = i + 2;
      end
    end
    check("tmo_seen",    found,   1'b1);
    check("tmo_latency", elapsed, T);
    frame_q.delete();
    model_error(ERR_TIMEOUT);
    check("tmo_code", err_code, ERR_TIMEOUT);
    check("tmo_busy", busy,     1'b0);
    check("tmo_ecnt", err_cnt,  m_ecnt);
    @(negedge clk_50m);
    check("tmo_width", frm_err, 1'b0);
    send_frame(8'h07, 8'h08, 16'hBEEF, 1'b0);
    check("post_tmo_wdata", frm_wdata, 16'hBEEF);

    // A byte landing in the expiry cycle wins over the timeout.
    send_byte(HDR, 0);
    send_byte(8'h01, 0);
    repeat (T - 2) @(negedge clk_50m);
    send_byte(8'h10, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h57, 0);
    check("race_wdata", frm_wdata, 16'h1234);
    check("race_ecnt",  err_cnt,   m_ecnt);

    // Randomized frames with occasional noise and corrupted checksums.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        nb = 8'($urandom);
        if (nb == HDR) nb = 8'hAA;
        send_byte(nb, $urandom_range(0, 2));
      end
      send_frame(8'($urandom), 8'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a frame clears everything immediately.
    send_byte(HDR, 0);
    send_byte(8'h01, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_busy",  busy,      1'b0);
    check("mid_rst_valid", frm_valid, 1'b0);
    check("mid_rst_err",   frm_err,   1'b0);
    check_regs("mid_rst");
    @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
    send_byte(8'h01, 0);
    check("post_rst_idle", busy, 1'b0);
    send_frame(8'h01, 8'h10, 16'h1234, 1'b0);
    check("post_rst_fcnt", frame_cnt, 8'd1);
    check("post_rst_ecnt", err_cnt,   8'd0);

    // Counter wrap and saturation.
    do_reset();
    for (int n = 0; n < 256; n++)
      send_frame(8'($urandom), 8'($urandom), 16'($urandom), 1'b0);
    check("fcnt_wrap", frame_cnt, 8'd0);
    for (int n = 0; n < 300; n++)
      send_frame(8'($urandom), 8'($urandom), 16'($urandom), 1'b1);
    check("ecnt_sat", err_cnt, 8'd255);

    repeat (4) @(negedge clk_50m);
    check("clr_per_byte", clr_pulses, sent);
    check("valid_err_excl", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
